fetch_unit: RTL



---
 rtl/fetch_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order memory requests and
// hands (pc, instr) pairs to IF/ID under valid/ready, flushing on redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          DEPTH          = 4,
    localparam int         SYS_ADDR_SPACE = 32,
    localparam int         INST_WIDTH     = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,

    output logic                      imem_req_o,
    output logic [SYS_ADDR_SPACE-1:0] imem_addr_o,
    input  logic                      imem_gnt_i,
    input  logic                      imem_rvalid_i,
    input  logic [INST_WIDTH-1:0]     imem_rdata_i,

    input  logic                      redirect_i,
    input  logic [SYS_ADDR_SPACE-1:0] redirect_pc_i,

    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [INST_WIDTH-1:0]     instr_o,
    output logic [SYS_ADDR_SPACE-1:0] pc_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W:0]            DEPTH_SUM  = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]          CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0]          PTR_ONE    = PTR_W'(1);
    localparam logic [SYS_ADDR_SPACE-1:0] PC_STEP    = SYS_ADDR_SPACE'(4);
    localparam logic [SYS_ADDR_SPACE-1:0] ALIGN_MASK = ~SYS_ADDR_SPACE'(3);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("fetch_unit: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    // Program counter and bookkeeping.
    logic [SYS_ADDR_SPACE-1:0] fetch_pc;
    logic [PTR_W-1:0]          head_ptr;
    logic [PTR_W-1:0]          tail_ptr;
    logic [PTR_W-1:0]          fill_ptr;
    logic [CNT_W-1:0]          alloc_cnt;
    logic [CNT_W-1:0]          pend_cnt;
    logic [CNT_W-1:0]          drop_cnt;

    // Queue storage.
    logic [SYS_ADDR_SPACE-1:0] q_pc    [DEPTH];
    logic [INST_WIDTH-1:0]     q_instr [DEPTH];
    logic [DEPTH-1:0]          q_filled;

    logic credit_ok;
    logic grant;
    logic pop;
    logic rsp_drop;
    logic rsp_fill;

    // Dropped responses still occupy a memory slot, so they consume credit too.
    assign credit_ok = ({1'b0, alloc_cnt} + {1'b0, drop_cnt}) < DEPTH_SUM;

    // NOTE: the request is gated with rst_n_i directly so it reads 0 while reset
    // is held, even though every counter already shows free credit.
    assign imem_req_o  = rst_n_i && !redirect_i && credit_ok;
    assign imem_addr_o = fetch_pc;
    assign grant       = imem_req_o && imem_gnt_i;

    assign valid_o = q_filled[head_ptr] && !redirect_i;
    assign instr_o = q_instr[head_ptr];
    assign pc_o    = q_pc[head_ptr];
    assign pop     = valid_o && ready_i;

    assign rsp_drop = imem_rvalid_i && (drop_cnt != '0);
    assign rsp_fill = imem_rvalid_i && (drop_cnt == '0) && (pend_cnt != '0);

    // NOTE: all state is updated with non-blocking assignments so every branch
    // sees the pre-edge values of the counters and pointers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fetch_pc  <= RESET_PC;
            head_ptr  <= '0;
            tail_ptr  <= '0;
            fill_ptr  <= '0;
            alloc_cnt <= '0;
            pend_cnt  <= '0;
            drop_cnt  <= '0;
        end else if (redirect_i) begin
            fetch_pc  <= redirect_pc_i & ALIGN_MASK;
            head_ptr  <= '0;
            tail_ptr  <= '0;
            fill_ptr  <= '0;
            alloc_cnt <= '0;
            pend_cnt  <= '0;
            // Every unfilled entry still has a response coming; a response landing
            // in this very cycle has already been accounted for.
            drop_cnt  <= drop_cnt + pend_cnt - CNT_W'(rsp_drop || rsp_fill);
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + PC_STEP;
                tail_ptr <= tail_ptr + PTR_ONE;
            end
            if (pop) begin
                head_ptr <= head_ptr + PTR_ONE;
            end
            if (rsp_fill) begin
                fill_ptr <= fill_ptr + PTR_ONE;
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - CNT_ONE;
            end
            alloc_cnt <= alloc_cnt + CNT_W'(grant) - CNT_W'(pop);
            pend_cnt  <= pend_cnt + CNT_W'(grant) - CNT_W'(rsp_fill);
        end
    end

    // NOTE: the queue payload is reset as well because pc_o/instr_o are read
    // straight from the head entry and must show zero out of reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
            q_filled <= '0;
        end else if (redirect_i) begin
            q_filled <= '0;
        end else begin
            // Grant, fill and pop always address distinct entries.
            if (grant) begin
                q_pc[tail_ptr]     <= fetch_pc;
                q_filled[tail_ptr] <= 1'b0;
            end
            if (rsp_fill) begin
                q_instr[fill_ptr]  <= imem_rdata_i;
                q_filled[fill_ptr] <= 1'b1;
            end
            if (pop) begin
                q_filled[head_ptr] <= 1'b0;
            end
        end
    end

    // A response with nothing pending and nothing to drop is a memory protocol error.
    assert property (@(posedge clk_i) disable iff (!rst_n_i)
        imem_rvalid_i |-> (drop_cnt != '0 || pend_cnt != '0));

endmodule
